// File: rtl/gmm_fifo_pkg.sv
// Shared types and elaboration-time helpers for the GMM width-converting FIFO.
// Mode derivation, ratio/count-width math and the width-compatibility check
// all live here so every FIFO flavour computes them identically.
package gmm_fifo_pkg;

  typedef enum logic [1:0] {
    MODE_DOWN  = 2'd0,
    MODE_UP    = 2'd1,
    MODE_EQUAL = 2'd2
  } fifo_mode_e;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res = res + 1;
    return res;
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_w(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Number of narrow slices per wide word
  function automatic int calc_ratio(input int win, input int wout);
    return max_w(win, wout) / min_w(win, wout);
  endfunction

  // Occupancy counter width, able to hold DEPTH*RATIO
  function automatic int calc_width_c(input int depth, input int ratio);
    return clog2(depth * ratio + 1);
  endfunction

  function automatic fifo_mode_e calc_mode(input int win, input int wout);
    if (win > wout) return MODE_DOWN;
    if (win < wout) return MODE_UP;
    return MODE_EQUAL;
  endfunction

  // The wider port must be an integer multiple of the narrower one
  function automatic bit widths_ok(input int win, input int wout);
    return (max_w(win, wout) % min_w(win, wout)) == 0;
  endfunction

endpackage

// File: rtl/gmm_fifo_ram.sv
// Storage array for the width-converting FIFO: one synchronous write port and
// one asynchronous read port, so the FIFO head is visible without a read cycle.
module gmm_fifo_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: one wide word per enabled clock
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gmm_width_conv_fifo.sv
// Width-converting first-word-fall-through FIFO for the GMM datapath.
// Handles downsizing (wide in, narrow out), upsizing (narrow in, wide out)
// and equal widths; the mode is derived from WIDTH_IN/WIDTH_OUT.
// Occupancy is always tracked in narrow units.
// Optional build macro GMM_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// outputs; without it those ports do not exist.
module gmm_width_conv_fifo
  import gmm_fifo_pkg::*;
#(
  parameter int WIDTH_IN  = 24,
  parameter int WIDTH_OUT = 8,
  parameter int DEPTH     = 128,
  parameter int MSB_FIRST = 1,
  parameter int AF_LEVEL  = DEPTH * calc_ratio(WIDTH_IN, WIDTH_OUT) - calc_ratio(WIDTH_IN, WIDTH_OUT),
  parameter int AE_LEVEL  = 0
) (
  input  logic                                               clk,
  input  logic                                               reset_n,
  input  logic                                               flush,
  input  logic                                               write_en,
  input  logic [WIDTH_IN-1:0]                                datain,
  input  logic                                               read_en,
  output logic [WIDTH_OUT-1:0]                               dataout,
  output logic [calc_width_c(DEPTH, calc_ratio(WIDTH_IN, WIDTH_OUT))-1:0] fifo_count,
  output logic                                               empty,
  output logic                                               full,
  output logic                                               almost_empty,
  output logic                                               almost_full
`ifdef GMM_FIFO_ERR_FLAGS_EN
  ,
  output logic                                               overflow,
  output logic                                               underflow
`endif
);

  localparam int         RATIO    = calc_ratio(WIDTH_IN, WIDTH_OUT);
  localparam int         WIDTH_C  = calc_width_c(DEPTH, RATIO);
  localparam int         WIDE_W   = max_w(WIDTH_IN, WIDTH_OUT);
  localparam int         NARROW_W = min_w(WIDTH_IN, WIDTH_OUT);
  localparam int         AW       = clog2(DEPTH);
  localparam fifo_mode_e MODE     = calc_mode(WIDTH_IN, WIDTH_OUT);

  localparam logic [WIDTH_C-1:0] CAP_C     = WIDTH_C'(DEPTH * RATIO);
  localparam logic [WIDTH_C-1:0] FULL_TH_C = WIDTH_C'((DEPTH - 1) * RATIO);
  localparam logic [WIDTH_C-1:0] RATIO_C   = WIDTH_C'(RATIO);
  // Narrow units added per accepted write / removed per accepted read
  localparam logic [WIDTH_C-1:0] WR_INC    = (MODE == MODE_UP)   ? WIDTH_C'(1) : RATIO_C;
  localparam logic [WIDTH_C-1:0] RD_DEC    = (MODE == MODE_DOWN) ? WIDTH_C'(1) : RATIO_C;
  localparam logic [AW-1:0]      ADDR_LAST = AW'(DEPTH - 1);

  if (!widths_ok(WIDTH_IN, WIDTH_OUT)) begin : g_bad_widths
    $error("gmm_width_conv_fifo: larger width must be a multiple of the smaller");
  end

  logic [WIDTH_C-1:0]   count;
  logic [AW-1:0]        wr_addr;
  logic [AW-1:0]        rd_addr;
  logic                 wr_valid;
  logic                 rd_valid;
  logic                 wr_adv;
  logic                 rd_adv;
  logic                 mem_we;
  logic [WIDE_W-1:0]    mem_wdata;
  logic [WIDE_W-1:0]    rd_word;
  logic [WIDTH_OUT-1:0] rd_data;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + 1'b1;
  endfunction

  assign wr_valid = write_en && !full;
  assign rd_valid = read_en && !empty;

  // Status flags decoded from the registered occupancy
  always_comb begin
    empty        = (count == '0);
    full         = (count > FULL_TH_C);
    if (MODE == MODE_UP) begin
      empty      = (count < RATIO_C);
      full       = (count == CAP_C);
    end
    almost_full  = ($unsigned(32'(count)) >= $unsigned(32'(AF_LEVEL)));
    almost_empty = ($unsigned(32'(count)) <= $unsigned(32'(AE_LEVEL)));
  end

  // Occupancy and word addresses; flush wins over any same-cycle read/write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (flush) begin
      count   <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      count <= count + (wr_valid ? WR_INC : '0) - (rd_valid ? RD_DEC : '0);
      if (wr_adv) wr_addr <= next_addr(wr_addr);
      if (rd_adv) rd_addr <= next_addr(rd_addr);
    end
  end

  gmm_fifo_ram #(
    .WIDTH (WIDE_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (mem_wdata),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  if (MODE == MODE_DOWN) begin : g_down
    localparam int            LW   = clog2(RATIO);
    localparam logic [LW-1:0] LAST = LW'(RATIO - 1);

    logic [LW-1:0]       rd_lane;
    logic [LW-1:0]       rd_idx;
    logic [NARROW_W-1:0] lanes [RATIO];

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
      assign lanes[g] = rd_word[g*NARROW_W +: NARROW_W];
    end

    // Lane 0 is the first slice out; it sits in the MSBs when MSB_FIRST is set
    assign rd_idx = (MSB_FIRST != 0) ? (LAST - rd_lane) : rd_lane;

    // Read lane counter: the word is retired after its last slice is popped
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      rd_lane <= '0;
      else if (flush)    rd_lane <= '0;
      else if (rd_valid) rd_lane <= (rd_lane == LAST) ? '0 : rd_lane + 1'b1;
    end

    assign rd_adv    = rd_valid && (rd_lane == LAST);
    assign wr_adv    = wr_valid;
    assign mem_we    = wr_valid;
    assign mem_wdata = datain;
    assign rd_data   = lanes[rd_idx];
  end else if (MODE == MODE_UP) begin : g_up
    localparam int            LW   = clog2(RATIO);
    localparam logic [LW-1:0] LAST = LW'(RATIO - 1);

    logic [LW-1:0]     wr_lane;
    logic [LW-1:0]     wr_idx;
    logic [WIDE_W-1:0] pack;
    logic [WIDE_W-1:0] wr_word;

    assign wr_idx = (MSB_FIRST != 0) ? (LAST - wr_lane) : wr_lane;

    // Current pack contents with the incoming slice merged into its lane
    for (genvar g = 0; g < RATIO; g++) begin : g_lane
      assign wr_word[g*NARROW_W +: NARROW_W] =
        (wr_idx == LW'(g)) ? datain : pack[g*NARROW_W +: NARROW_W];
    end

    // Write lane counter: the word commits to memory on its last slice
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      wr_lane <= '0;
      else if (flush)    wr_lane <= '0;
      else if (wr_valid) wr_lane <= (wr_lane == LAST) ? '0 : wr_lane + 1'b1;
    end

    // Pack register collects slices; flush discards a partial word
    always_ff @(posedge clk) begin
      if (flush)         pack <= '0;
      else if (wr_valid) pack <= wr_word;
    end

    assign wr_adv    = wr_valid && (wr_lane == LAST);
    assign mem_we    = wr_adv;
    assign mem_wdata = wr_word;
    assign rd_adv    = rd_valid;
    assign rd_data   = rd_word;
  end else begin : g_equal
    assign wr_adv    = wr_valid;
    assign mem_we    = wr_valid;
    assign mem_wdata = datain;
    assign rd_adv    = rd_valid;
    assign rd_data   = rd_word;
  end

  assign fifo_count = count;
  assign dataout    = empty ? '0 : rd_data;

`ifdef GMM_FIFO_ERR_FLAGS_EN
  // Sticky error flags: rejected write while full, rejected read while empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && full)  overflow  <= 1'b1;
      if (read_en  && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gmm_width_conv_fifo.sv
// Testbench for gmm_width_conv_fifo: three instances (24->8 downsizing,
// 8->32 upsizing with LSB-first packing, 8->8 equal width with DEPTH=3).
module tb_gmm_width_conv_fifo;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Downsizing instance, DEPTH=4, AF_LEVEL defaults to 9
  logic        d_flush = 0, d_we = 0, d_re = 0;
  logic [23:0] d_din = '0;
  logic [7:0]  d_dout;
  logic [3:0]  d_cnt;
  logic        d_empty, d_full, d_ae, d_af;
  // Upsizing instance, DEPTH=4, AF_LEVEL defaults to 12
  logic        u_flush = 0, u_we = 0, u_re = 0;
  logic [7:0]  u_din = '0;
  logic [31:0] u_dout;
  logic [4:0]  u_cnt;
  logic        u_empty, u_full, u_ae, u_af;
  // Equal-width instance, DEPTH=3
  logic        e_flush = 0, e_we = 0, e_re = 0;
  logic [7:0]  e_din = '0;
  logic [7:0]  e_dout;
  logic [1:0]  e_cnt;
  logic        e_empty, e_full, e_ae, e_af;
`ifdef GMM_FIFO_ERR_FLAGS_EN
  logic d_ovf, d_unf, u_ovf, u_unf, e_ovf, e_unf;
`endif

  gmm_width_conv_fifo #(.WIDTH_IN(24), .WIDTH_OUT(8), .DEPTH(4), .MSB_FIRST(1)) u_down (
    .clk(clk), .reset_n(reset_n), .flush(d_flush), .write_en(d_we), .datain(d_din),
    .read_en(d_re), .dataout(d_dout), .fifo_count(d_cnt), .empty(d_empty), .full(d_full),
    .almost_empty(d_ae), .almost_full(d_af)
`ifdef GMM_FIFO_ERR_FLAGS_EN
    , .overflow(d_ovf), .underflow(d_unf)
`endif
  );

  gmm_width_conv_fifo #(.WIDTH_IN(8), .WIDTH_OUT(32), .DEPTH(4), .MSB_FIRST(0)) u_up (
    .clk(clk), .reset_n(reset_n), .flush(u_flush), .write_en(u_we), .datain(u_din),
    .read_en(u_re), .dataout(u_dout), .fifo_count(u_cnt), .empty(u_empty), .full(u_full),
    .almost_empty(u_ae), .almost_full(u_af)
`ifdef GMM_FIFO_ERR_FLAGS_EN
    , .overflow(u_ovf), .underflow(u_unf)
`endif
  );

  gmm_width_conv_fifo #(.WIDTH_IN(8), .WIDTH_OUT(8), .DEPTH(3), .MSB_FIRST(1)) u_eq (
    .clk(clk), .reset_n(reset_n), .flush(e_flush), .write_en(e_we), .datain(e_din),
    .read_en(e_re), .dataout(e_dout), .fifo_count(e_cnt), .empty(e_empty), .full(e_full),
    .almost_empty(e_ae), .almost_full(e_af)
`ifdef GMM_FIFO_ERR_FLAGS_EN
    , .overflow(e_ovf), .underflow(e_unf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wr, rd, fl;
    logic [23:0] din;
    int          cnt;
    bit          emp, ful, af, ae, ovf, unf;
  } vec_t;

  function automatic vec_t mk(bit wr, bit rd, bit fl, logic [23:0] din, int cnt,
                              bit emp, bit ful, bit af, bit ae, bit ovf, bit unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.din = din; v.cnt = cnt;
    v.emp = emp; v.ful = ful; v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  vec_t        vt [24];
  logic [7:0]  dq [$];     // expected byte stream for the downsizing instance
  logic [7:0]  eq_q [$];   // expected word stream for the equal-width instance
  bit          m_wv, m_rv;
  int          sent, got;
  logic [7:0]  up_bytes [8];
  logic [7:0]  exp_b;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    // wr rd fl din           cnt emp ful af ae ovf unf
    vt[0]  = mk(1, 0, 0, 24'hA1B2C3,  3, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 0, 24'h0,       2, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 1, 0, 24'h0,       1, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(0, 1, 0, 24'h0,       0, 1, 0, 0, 1, 0, 0);
    vt[4]  = mk(0, 1, 0, 24'h0,       0, 1, 0, 0, 1, 0, 1);
    vt[5]  = mk(1, 0, 0, 24'h112233,  3, 0, 0, 0, 0, 0, 1);
    vt[6]  = mk(1, 0, 0, 24'h445566,  6, 0, 0, 0, 0, 0, 1);
    vt[7]  = mk(1, 0, 0, 24'h778899,  9, 0, 0, 1, 0, 0, 1);
    vt[8]  = mk(1, 0, 0, 24'hAABBCC, 12, 0, 1, 1, 0, 0, 1);
    vt[9]  = mk(1, 0, 0, 24'hDDEEFF, 12, 0, 1, 1, 0, 1, 1);
    vt[10] = mk(0, 1, 0, 24'h0,      11, 0, 1, 1, 0, 1, 1);
    vt[11] = mk(0, 1, 0, 24'h0,      10, 0, 1, 1, 0, 1, 1);
    vt[12] = mk(0, 1, 0, 24'h0,       9, 0, 0, 1, 0, 1, 1);
    for (int i = 13; i <= 18; i++) vt[i] = mk(0, 1, 0, 24'h0, 21 - i, 0, 0, 0, 0, 1, 1);
    vt[19] = mk(1, 1, 0, 24'h010203,  5, 0, 0, 0, 0, 1, 1);
    vt[20] = mk(0, 1, 0, 24'h0,       4, 0, 0, 0, 0, 1, 1);
    vt[21] = mk(1, 0, 0, 24'h040506,  7, 0, 0, 0, 0, 1, 1);
    vt[22] = mk(1, 1, 1, 24'h070809,  0, 1, 0, 0, 1, 0, 0);
    vt[23] = mk(1, 0, 0, 24'h0A0B0C,  3, 0, 0, 0, 0, 0, 0);

    // Reset values while reset_n is held low
    #2;
    chk("rst.down.count", d_cnt, 0);
    chk("rst.down.empty", d_empty, 1);
    chk("rst.down.full", d_full, 0);
    chk("rst.down.ae", d_ae, 1);
    chk("rst.down.af", d_af, 0);
    chk("rst.down.dout", d_dout, 0);
    chk("rst.up.count", u_cnt, 0);
    chk("rst.up.empty", u_empty, 1);
    chk("rst.up.dout", u_dout, 0);
    chk("rst.eq.empty", e_empty, 1);
`ifdef GMM_FIFO_ERR_FLAGS_EN
    chk("rst.down.ovf", d_ovf, 0);
    chk("rst.down.unf", d_unf, 0);
`endif
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // Downsizing table
    for (int i = 0; i < 24; i++) begin
      m_wv = vt[i].wr && (dq.size() <= 9);
      m_rv = vt[i].rd && (dq.size() != 0);
      d_we = vt[i].wr; d_re = vt[i].rd; d_flush = vt[i].fl; d_din = vt[i].din;
      @(posedge clk); #1;
      d_we = 0; d_re = 0; d_flush = 0;
      if (vt[i].fl) dq.delete();
      else begin
        if (m_rv) void'(dq.pop_front());
        if (m_wv) begin
          dq.push_back(vt[i].din[23:16]);
          dq.push_back(vt[i].din[15:8]);
          dq.push_back(vt[i].din[7:0]);
        end
      end
      exp_b = (dq.size() != 0) ? dq[0] : 8'h00;
      chk($sformatf("down[%0d].count", i), d_cnt, vt[i].cnt);
      chk($sformatf("down[%0d].empty", i), d_empty, vt[i].emp);
      chk($sformatf("down[%0d].full", i), d_full, vt[i].ful);
      chk($sformatf("down[%0d].af", i), d_af, vt[i].af);
      chk($sformatf("down[%0d].ae", i), d_ae, vt[i].ae);
      chk($sformatf("down[%0d].dout", i), d_dout, exp_b);
`ifdef GMM_FIFO_ERR_FLAGS_EN
      chk($sformatf("down[%0d].ovf", i), d_ovf, vt[i].ovf);
      chk($sformatf("down[%0d].unf", i), d_unf, vt[i].unf);
`endif
    end

    // Upsizing: 11,22,33,44 pack LSB-first; then flush drops a partial word
    up_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) begin
      u_we = 1; u_din = up_bytes[i];
      @(posedge clk); #1;
      u_we = 0;
      chk($sformatf("up.w%0d.count", i), u_cnt, i + 1);
      chk($sformatf("up.w%0d.empty", i), u_empty, (i < 3) ? 1 : 0);
      chk($sformatf("up.w%0d.dout", i), u_dout, (i < 3) ? 32'h0 : 32'h44332211);
    end
    u_re = 1; @(posedge clk); #1; u_re = 0;
    chk("up.rd.count", u_cnt, 0);
    chk("up.rd.empty", u_empty, 1);
    chk("up.rd.dout", u_dout, 0);
    u_we = 1; u_din = 8'hEE; @(posedge clk); #1;
    u_din = 8'hFF; @(posedge clk); #1; u_we = 0;
    chk("up.partial.count", u_cnt, 2);
    u_flush = 1; @(posedge clk); #1; u_flush = 0;
    chk("up.flush.count", u_cnt, 0);
    for (int i = 4; i < 8; i++) begin
      u_we = 1; u_din = up_bytes[i]; @(posedge clk); #1;
    end
    u_we = 0;
    chk("up.after_flush.count", u_cnt, 4);
    chk("up.after_flush.dout", u_dout, 32'hDDCCBBAA);
    u_re = 1; @(posedge clk); #1; u_re = 0;
    chk("up.after_flush.rd", u_cnt, 0);

    // Equal width, DEPTH=3: streamed traffic wrapping the addresses
    sent = 0; got = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      e_we = (sent < 10);
      e_din = 8'(8'h50 + sent);
      e_re = ((c % 3) != 0);
      m_wv = e_we && (eq_q.size() < 3);
      m_rv = e_re && (eq_q.size() != 0);
      if (m_rv) chk($sformatf("eq.data%0d", got), e_dout, eq_q[0]);
      @(posedge clk); #1;
      if (m_rv) begin void'(eq_q.pop_front()); got++; end
      if (m_wv) begin eq_q.push_back(e_din); sent++; end
      chk($sformatf("eq.c%0d.count", c), e_cnt, eq_q.size());
    end
    e_we = 0; e_re = 0;
    chk("eq.words_out", got, 10);

    // Asynchronous reset mid-stream, away from any clock edge
    d_we = 1; d_din = 24'h123456; @(posedge clk); #1; d_we = 0;
    chk("mid.down.count", d_cnt, 6);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.down.count", d_cnt, 0);
    chk("arst.down.empty", d_empty, 1);
    chk("arst.down.full", d_full, 0);
    chk("arst.down.ae", d_ae, 1);
    chk("arst.down.af", d_af, 0);
    chk("arst.down.dout", d_dout, 0);
    chk("arst.eq.count", e_cnt, 0);
`ifdef GMM_FIFO_ERR_FLAGS_EN
    chk("arst.down.ovf", d_ovf, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gmm_width_conv_fifo.md
# gmm_width_conv_fifo

Parametrised width-converting FIFO for the GMM background-subtraction datapath. It supports both downsizing (wide in, narrow out), upsizing (narrow in, wide out) and equal widths. Slice order is selectable, with programmable almost-full/almost-empty levels and a synchronous flush. It sits between pixel-stream producers (RGB packers, frame readers) and per-channel GMM update stages. It is the general successor to the fixed 24→8 downsizing project FIFO.

## Interface
Parameters:
- WIDTH_IN, 24, write data width
- WIDTH_OUT, 8, read data width; larger of WIDTH_IN/WIDTH_OUT must be an integer multiple of the smaller
- DEPTH, 128, storage entries, each max(WIDTH_IN,WIDTH_OUT) bits; ≥2, need not be a power of two
- MSB_FIRST, 1, 1: first narrow slice occupies MSBs of the wide word; 0: LSBs
- AF_LEVEL, DEPTH*RATIO-RATIO, almost_full threshold in narrow units
- AE_LEVEL, 0, almost_empty threshold in narrow units

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear
- write_en  in  1  write request
- datain  in  WIDTH_IN  write data
- read_en  in  1  read/pop request
- dataout  out  WIDTH_OUT  first-word-fall-through read data
- fifo_count  out  WIDTH_C  occupancy in narrow units
- empty, full, almost_empty, almost_full  out  1 each  status flags

## Operation
- RATIO = max/min width; WIDTH_C = clog2(DEPTH*RATIO+1). Mode DOWN, UP, or EQUAL (RATIO=1) is derived from the parameters.
- write_valid = write_en & !full. read_valid = read_en & !empty. Invalid requests are ignored; state is unchanged.
- DOWN mode:
  - A write stores one wide word; count += RATIO.
  - Each read pops one slice; count -= 1.
  - The read lane counter runs 0..RATIO-1. The read address advances after the last lane.
  - full = count > (DEPTH-1)*RATIO. empty = count == 0.
- UP mode:
  - Writes fill a pack register lane by lane; count += 1.
  - On the RATIO-th lane, the completed word commits to memory and the write address advances.
  - A read pops one wide word; count -= RATIO.
  - empty = count < RATIO. full = count == DEPTH*RATIO.
- EQUAL mode: plain FIFO, ±1 per operation.
- Simultaneous valid read and write: both are performed; count takes the net change.
- Addresses wrap from DEPTH-1 to 0.
- Status flags: almost_full = count ≥ AF_LEVEL; almost_empty = count ≤ AE_LEVEL.
- dataout is forced to 0 while empty. Otherwise it is the current slice or word, selected per MSB_FIRST.
- flush takes priority over read and write in the same cycle. It clears count, addresses, lane counters and the pack register; partial UP-mode data is discarded.
- Reset values: count 0, addresses and lanes 0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), dataout=0.

## Timing
- All state updates on the rising edge of clk. reset_n acts immediately and asynchronously, including mid-stream.
- Flags are combinational from the registered count.
- Write-to-read latency: a write at edge N makes data visible on dataout, with empty deasserted, in the cycle after edge N. In UP mode this applies to the write of the final lane.
- Memory is read combinationally, so dataout changes in the cycle after each pop.

## Configuration
- GMM_FIFO_ERR_FLAGS_EN defined: adds outputs overflow and underflow (1 bit each, reset 0).
  - Both are sticky; they set on write_en&full or read_en&empty respectively.
  - Both are cleared by flush or reset.
- Undefined: these ports and their logic are absent.

## Structure
- Package gmm_fifo_pkg holds:
  - clog2 function
  - fifo_mode_e typedef (DOWN/UP/EQUAL)
  - RATIO/WIDTH_C derivation helpers
  - an elaboration check that one width is a multiple of the other
- Sub-module gmm_fifo_ram: DEPTH×max-width, one synchronous write port, one asynchronous read port.

## Test plan
- Default params, DEPTH=4:
  - Reset, write 0xA1B2C3 → next cycle empty=0, count=3, dataout=0xA1.
  - Three reads → 0xB2, then 0xC3, then empty=1, count=0, dataout=0.
- Default params, DEPTH=4, overflow:
  - Write 4 words → count=12, full=1.
  - 5th write ignored (count stays 12; overflow=1 with GMM_FIFO_ERR_FLAGS_EN).
  - 3 reads → count=9, full=0.
- Default params at count=3: read_en and write_en in the same cycle → count=5, data order preserved.
- UP mode, WIDTH_IN=8, WIDTH_OUT=32, MSB_FIRST=0:
  - Write 0x11, 0x22, 0x33 → empty=1, count=3.
  - Write 0x44 → dataout=0x44332211, count=4.
  - One read → count=0.
- DEPTH=3, EQUAL mode, continuous writes and reads of 10 words: output matches input order across address wrap.
- At count=7, assert flush with read_en and write_en high → next cycle count=0, empty=1. Then deassert reset_n mid-stream → all outputs at reset values immediately.
